// File: rtl/dmem_ctrl.sv
// Data-memory controller: word RAM with registered read,
// one stall cycle per load, sticky error on bad accesses.
module dmem_ctrl #(
  parameter int ADDR_BITS = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [31:0] aluout,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        stall,
  output logic        err
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RESP = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        we;

  logic [31:0] mem_q [2**ADDR_BITS];

  logic [ADDR_BITS-1:0] idx;
  logic                 aligned;
  logic                 in_idle;

  assign idx     = aluout[ADDR_BITS+1:2];
  assign aligned = (aluout[1:0] == 2'b00);
  assign in_idle = (state_q == IDLE);

  // Upper address bits alias by design.
  logic unused_hi;
  assign unused_hi = ^aluout[31:ADDR_BITS+2];

  assign stall = in_idle & memread & ~memwrite & aligned;

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    we      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (memwrite) begin
          we = aligned;
          if (!aligned || memread) err_d = 1'b1;
        end else if (memread) begin
          if (aligned) begin
            state_d = RESP;
            rdata_d = mem_q[idx];
          end else begin
            rdata_d = 32'h0;
            err_d   = 1'b1;
          end
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // RAM contents survive reset; only the write is blocked.
  always_ff @(posedge clk) begin
    if (we && !reset) mem_q[idx] <= writedata;
  end

  assign readdata = rdata_q;
  assign err      = err_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: per-cycle expectations
// queued by the driver, compared by a separate monitor.
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        memread;
  logic        memwrite;
  logic [31:0] aluout;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        stall;
  logic        err;

  always #5 clk = ~clk;

  dmem_ctrl #(.ADDR_BITS(6)) dut (
    .clk(clk),
    .reset(reset),
    .memread(memread),
    .memwrite(memwrite),
    .aluout(aluout),
    .writedata(writedata),
    .readdata(readdata),
    .stall(stall),
    .err(err)
  );

  typedef struct packed {
    logic        st;
    logic [31:0] rd;
    logic        er;
  } exp_t;

  exp_t q[$];
  int errs = 0;
  int checks = 0;

  logic [31:0] mem_m [64];
  logic [31:0] exp_rd;
  logic        exp_err;

  function automatic int widx(input logic [31:0] a);
    return (a / 4) % 64;
  endfunction

  function automatic logic is_al(input logic [31:0] a);
    return (a % 4) == 0;
  endfunction

  // Monitor: one expectation per cycle, sampled mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (stall !== e.st) begin
          errs++;
          $display("FAIL stall t=%0t got=%b exp=%b",
                   $time, stall, e.st);
        end
        checks++;
        if (readdata !== e.rd) begin
          errs++;
          $display("FAIL readdata t=%0t got=%h exp=%h",
                   $time, readdata, e.rd);
        end
        checks++;
        if (err !== e.er) begin
          errs++;
          $display("FAIL err t=%0t got=%b exp=%b",
                   $time, err, e.er);
        end
      end
    end
  end

  task automatic drive(input logic rd, input logic wr,
                       input logic [31:0] a,
                       input logic [31:0] d,
                       input logic rst, input logic st);
    exp_t e;
    memread   = rd;
    memwrite  = wr;
    aluout    = a;
    writedata = d;
    reset     = rst;
    e.st = st;
    e.rd = exp_rd;
    e.er = exp_err;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_idle();
    drive(1'b0, 1'b0, $urandom, $urandom, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, $urandom, $urandom, 1'b1, 1'b0);
    exp_rd  = 32'h0;
    exp_err = 1'b0;
  endtask

  task automatic do_store(input logic [31:0] a,
                          input logic [31:0] d,
                          input logic rst);
    drive(1'b0, 1'b1, a, d, rst, 1'b0);
    if (rst) begin
      exp_rd  = 32'h0;
      exp_err = 1'b0;
    end else if (is_al(a)) begin
      mem_m[widx(a)] = d;
    end else begin
      exp_err = 1'b1;
    end
  endtask

  task automatic do_conflict(input logic [31:0] a,
                             input logic [31:0] d);
    drive(1'b1, 1'b1, a, d, 1'b0, 1'b0);
    if (is_al(a)) mem_m[widx(a)] = d;
    exp_err = 1'b1;
  endtask

  // A load is two cycles; the second carries junk inputs
  // that must all be ignored.
  task automatic do_load(input logic [31:0] a,
                         input logic rst_resp);
    if (is_al(a)) begin
      drive(1'b1, 1'b0, a, $urandom, 1'b0, 1'b1);
      exp_rd = mem_m[widx(a)];
      drive(1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)),
            $urandom, $urandom, rst_resp, 1'b0);
      if (rst_resp) begin
        exp_rd  = 32'h0;
        exp_err = 1'b0;
      end
    end else begin
      drive(1'b1, 1'b0, a, $urandom, 1'b0, 1'b0);
      exp_rd  = 32'h0;
      exp_err = 1'b1;
    end
  endtask

  function automatic logic [31:0] rnd_addr();
    logic [31:0] a;
    a = $urandom;
    if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
    return a;
  endfunction

  initial begin
    int op;
    memread   = 1'b0;
    memwrite  = 1'b0;
    aluout    = 32'h0;
    writedata = 32'h0;
    reset     = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    exp_rd  = 32'h0;
    exp_err = 1'b0;

    do_reset();
    repeat (5) do_idle();

    for (int i = 0; i < 64; i++)
      do_store(32'(i * 4), $urandom, 1'b0);

    do_store(32'h10, 32'hDEADBEEF, 1'b0);
    do_load(32'h10, 1'b0);
    do_store(32'h104, 32'h12345678, 1'b0);
    do_load(32'h004, 1'b0);
    do_load(32'h10, 1'b0);
    do_load(32'h004, 1'b0);
    do_store(32'h0C, 32'h0BADF00D, 1'b0);
    do_load(32'h0C, 1'b0);
    do_store(32'h8, 32'hCAFEF00D, 1'b1);
    do_load(32'h8, 1'b0);

    do_store(32'h12, 32'h55555555, 1'b0);
    do_load(32'h10, 1'b0);
    do_load(32'h13, 1'b0);
    do_idle();
    do_conflict(32'h20, 32'hA5A5A5A5);
    do_load(32'h20, 1'b0);
    do_load(32'h20, 1'b1);
    do_idle();
    do_load(32'h20, 1'b0);

    for (int n = 0; n < 400; n++) begin
      op = $urandom_range(0, 19);
      if (op < 6)
        do_store(rnd_addr(), $urandom, 1'b0);
      else if (op < 13)
        do_load(rnd_addr(), 1'b0);
      else if (op < 15)
        do_conflict(rnd_addr(), $urandom);
      else if (op < 17)
        do_idle();
      else if (op < 18)
        do_reset();
      else if (op < 19)
        do_load(rnd_addr(), 1'b1);
      else
        do_store(rnd_addr(), $urandom, 1'b1);
    end

    memread  = 1'b0;
    memwrite = 1'b0;
    reset    = 1'b0;
    for (int k = 0; k < 10 && q.size() > 0; k++)
      @(posedge clk);
    if (q.size() > 0) begin
      errs++;
      $display("FAIL drain left=%0d exp=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
